// File: rtl/kms_dispatch.sv
// kms_dispatch: turns toggle-signalled host events into mouse counters, OSD strobes and queued CIA keycodes.
// Latency: 1 cycle event->counters/FIFO, +1 to key_strobe; no input backpressure, keycodes into a full FIFO are dropped (err[0]).
module kms_dispatch #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 4096,
    parameter int GAP_CYCLES  = 64
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     kms_level,
    input  logic [1:0]               kms_type,
    input  logic [7:0]               kms_data,
    input  logic                     key_ack,
    input  logic                     err_clr,
    output logic [7:0]               mouse_x,
    output logic [7:0]               mouse_y,
    output logic [7:0]               key_data,
    output logic                     key_strobe,
    output logic [7:0]               osd_key,
    output logic                     osd_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy,
    output logic [1:0]               err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          prev_level, armed, ev;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, push, pop, timeout_err;

    assign ev   = armed & (kms_level ^ prev_level);
    assign full = (fifo_level == FULL_LVL);
    assign push = ev & (kms_type == 2'd2) & ~full;
    assign busy = (state != IDLE);

    // The first edge after reset only captures the level, so a toggle that
    // happened while in reset is never replayed.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prev_level <= 1'b0;
            armed      <= 1'b0;
        end else begin
            prev_level <= kms_level;
            armed      <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mouse_x    <= 8'h00;
            mouse_y    <= 8'h00;
            osd_key    <= 8'h00;
            osd_strobe <= 1'b0;
        end else begin
            osd_strobe <= ev & (kms_type == 2'd3);
            if (ev) begin
                case (kms_type)
                    2'd0:    mouse_x <= mouse_x + kms_data;
                    2'd1:    mouse_y <= mouse_y + kms_data;
                    2'd3:    osd_key <= kms_data;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wr_ptr] <= kms_data;
    end

    // Full is judged on the pre-edge occupancy, so a simultaneous pop does not rescue a write.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pop         = 1'b0;
        timeout_err = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop       = 1'b1;
                    state_nxt = WAIT;
                    cnt_nxt   = ACK_LOAD;
                end
            end
            WAIT: begin
                if (key_ack) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else if (cnt == '0) begin
                    timeout_err = 1'b1;
                    state_nxt   = GAP;
                    cnt_nxt     = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            key_data   <= 8'h00;
            key_strobe <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            key_strobe <= pop;
            if (pop)
                key_data <= mem[rd_ptr];
        end
    end

    // A new error on the same edge as err_clr leaves the flag set.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            err <= 2'b00;
        end else begin
            err[0] <= (ev & (kms_type == 2'd2) & full) | (err[0] & ~err_clr);
            err[1] <= timeout_err | (err[1] & ~err_clr);
        end
    end

endmodule

// File: tb/tb_kms_dispatch.sv
// Directed bench for kms_dispatch: mouse accumulation, keycode handshake, overflow/timeout, OSD, reset re-arm.
module tb_kms_dispatch;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       kms_level;
    logic [1:0] kms_type;
    logic [7:0] kms_data;
    logic       key_ack;
    logic       err_clr;
    logic [7:0] mouse_x, mouse_y, key_data, osd_key;
    logic       key_strobe, osd_strobe, busy;
    logic [3:0] fifo_level;
    logic [1:0] err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] sq_dat[$];
    int         sq_cyc[$];

    kms_dispatch #(.DEPTH(8), .ACK_TIMEOUT(16), .GAP_CYCLES(4)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .kms_level  (kms_level),
        .kms_type   (kms_type),
        .kms_data   (kms_data),
        .key_ack    (key_ack),
        .err_clr    (err_clr),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .key_data   (key_data),
        .key_strobe (key_strobe),
        .osd_key    (osd_key),
        .osd_strobe (osd_strobe),
        .fifo_level (fifo_level),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (key_strobe === 1'b1) begin
            sq_dat.push_back(key_data);
            sq_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic toggle(input logic [1:0] t, input logic [7:0] d);
        kms_type  = t;
        kms_data  = d;
        kms_level = ~kms_level;
        tick();
    endtask

    task automatic wait_strobe(input int max_cyc, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (key_strobe === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (busy === 1'b0 && fifo_level === 4'd0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, ok, 1'b1);
    endtask

    task automatic ack_third_cycle();
        tick();
        tick();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; kms_level = 1'b0; kms_type = 2'd0; kms_data = 8'h00;
        key_ack = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        chk("rst_mouse_x", mouse_x, 8'h00);
        chk("rst_mouse_y", mouse_y, 8'h00);
        chk("rst_key_data", key_data, 8'h00);
        chk("rst_key_strobe", key_strobe, 1'b0);
        chk("rst_osd", {osd_strobe, osd_key}, 9'h000);
        chk("rst_fifo_level", fifo_level, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 2'b00);
        reset = 1'b0;
        tick();
        tick();

        // Mouse accumulation with wrap-around
        toggle(2'd0, 8'h05);
        chk("mx_plus5", mouse_x, 8'h05);
        toggle(2'd0, 8'hFB);
        chk("mx_minus5", mouse_x, 8'h00);
        chk("my_untouched", mouse_y, 8'h00);
        toggle(2'd1, 8'hFF);
        chk("my_minus1", mouse_y, 8'hFF);
        toggle(2'd1, 8'h02);
        chk("my_wrap", mouse_y, 8'h01);
        toggle(2'd0, 8'h80);
        chk("mx_0x80", mouse_x, 8'h80);

        // Three keycodes back-to-back, ack in WAIT cycle 3
        sq_dat.delete(); sq_cyc.delete();
        toggle(2'd2, 8'h45);
        chk("k1_level_after_E", fifo_level, 4'd1);
        chk("k1_no_strobe_at_E", {busy, key_strobe}, 2'b00);
        toggle(2'd2, 8'h46);
        chk("k1_strobe_E1", {busy, key_strobe}, 2'b11);
        chk("k1_data", key_data, 8'h45);
        chk("k1_level_E1", fifo_level, 4'd1);
        toggle(2'd2, 8'h47);
        chk("k1_strobe_one_cycle", key_strobe, 1'b0);
        chk("k3_level_E2", fifo_level, 4'd2);
        tick();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_strobe(40, "k_strobe_seen");
            ack_third_cycle();
        end
        wait_idle(40, "k_idle_seen");
        chk("k_strobe_count", sq_dat.size(), 3);
        if (sq_dat.size() == 3) begin
            chk("k_order", {sq_dat[0], sq_dat[1], sq_dat[2]}, 24'h454647);
            chk("k_spacing_1", sq_cyc[1] - sq_cyc[0], 8);
            chk("k_spacing_2", sq_cyc[2] - sq_cyc[1], 8);
        end
        chk("k_err_clean", err, 2'b00);

        // Overflow and ack timeout: DEPTH+2 codes, no ack
        sq_dat.delete(); sq_cyc.delete();
        for (int i = 0; i < 9; i++) toggle(2'd2, 8'h10 + 8'(i));
        chk("ovf_full_level", fifo_level, 4'd8);
        chk("ovf_err_before", err, 2'b00);
        toggle(2'd2, 8'h19);
        chk("ovf_err0_set", err, 2'b01);
        chk("ovf_level_held", fifo_level, 4'd8);
        repeat (7) tick();
        chk("to_before_expiry", err, 2'b01);
        tick();
        chk("to_err1_set", err, 2'b11);
        wait_idle(400, "ovf_drain");
        chk("ovf_strobe_count", sq_dat.size(), 9);
        if (sq_dat.size() == 9) begin
            chk("ovf_first", sq_dat[0], 8'h10);
            chk("ovf_last", sq_dat[8], 8'h18);
            chk("to_spacing", sq_cyc[1] - sq_cyc[0], 21);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", err, 2'b00);

        // OSD during WAIT, then ack on the exact expiry cycle
        sq_dat.delete(); sq_cyc.delete();
        toggle(2'd2, 8'h33);
        tick();
        chk("osd_pre_strobe", {key_strobe, key_data}, 9'h133);
        tick();
        toggle(2'd3, 8'h81);
        chk("osd_strobe", {osd_strobe, osd_key}, 9'h181);
        chk("osd_fsm_untouched", {busy, fifo_level}, 5'h10);
        tick();
        chk("osd_strobe_one_cycle", {osd_strobe, osd_key}, 9'h081);
        repeat (12) tick();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        chk("expiry_ack_no_err", err, 2'b00);
        chk("expiry_ack_gap", busy, 1'b1);
        wait_idle(40, "expiry_idle");
        chk("expiry_strobe_count", sq_dat.size(), 1);

        // Reset in WAIT with 3 queued, level held high
        for (int i = 0; i < 4; i++) toggle(2'd2, 8'h60 + 8'(i));
        chk("rr_pre_level", fifo_level, 4'd3);
        chk("rr_pre_busy", busy, 1'b1);
        reset = 1'b1;
        kms_level = 1'b1;
        #1;
        chk("rr_outputs", {mouse_x, mouse_y, key_data, osd_key}, 32'h0);
        chk("rr_flags", {key_strobe, osd_strobe, busy, err, fifo_level}, 9'h000);
        tick();
        tick();
        sq_dat.delete(); sq_cyc.delete();
        reset = 1'b0;
        tick();
        chk("rr_arm_no_event", {busy, fifo_level}, 5'h00);
        repeat (3) tick();
        chk("rr_still_quiet", {busy, fifo_level, err}, 7'h00);
        chk("rr_no_strobes", sq_dat.size(), 0);
        toggle(2'd2, 8'h77);
        chk("rr_toggle_accepted", fifo_level, 4'd1);
        tick();
        chk("rr_key_out", {key_strobe, key_data}, 9'h177);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
